// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration checks for the digit-serial adder/subtractor.
// Holds the FSM encoding and the WIDTH/DIGIT legality function.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic bit params_ok(input int width, input int digit);
      return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Producer/consumer handshake bundle for the digit-serial adder.
// master = producer+consumer side, slave = the adder itself.
interface digit_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/digit_serial_adder_ripple.sv
// Combinational DIGIT-wide ripple-carry slice; zero latency, no flow control.
// Also exports the carry into its MSB so the caller can derive signed overflow.
module ripple_digit_add #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial a+b+cin / a-b-cin, LSB digit first; result valid NUM_DIGITS cycles after acceptance.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   digit_serial_adder_if.slave  bus
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIGITS - 1);

   if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_co, dig_cm;

   assign dig_a = op_a_q[int'(cnt_q)*DIGIT +: DIGIT];
   assign dig_b = op_b_q[int'(cnt_q)*DIGIT +: DIGIT];

   ripple_digit_add #(
      .DIGIT (DIGIT)
   ) u_slice (
      .x        (dig_a),
      .y        (dig_b),
      .ci       (carry_q),
      .s        (dig_s),
      .co       (dig_co),
      .c_msb_in (dig_cm)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               // Subtraction is a + ~b + ~borrow, so cout=1 means no borrow.
               op_a_d  = bus.a;
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ^ bus.cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_s;
            carry_d = dig_co;
            if (cnt_q == LAST_DIG) begin
               cout_d  = dig_co;
               ovf_d   = dig_co ^ dig_cm;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes operands DIGIT bits per clock, LSB digit first, through a DIGIT-wide ripple-carry slice.
- Trades latency for area in datapaths where a full-width combinational adder is too large.
- Sits between a producer and a consumer, with a valid/ready handshake on each side.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock. Range 1..WIDTH.
- NUM_DIGITS, WIDTH/DIGIT, derived (localparam). Number of RUN cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an operand set.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in (add) or borrow in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of MSB. In sub mode 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; sum=0, cout=0, overflow=0, out_valid=0; internal counter, operand and carry registers cleared.
  - in_ready decodes state, so it reads 1 during reset. Inputs are ignored while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture a into op_a, capture (sub ? ~b : b) into op_b, set carry=(sub ? ~cin : cin), clear digit counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add digit k of op_a, digit k of op_b and carry in the slice.
  - Slice result goes into digit k of the result register; slice carry-out goes into carry.
  - Counter increments. On counter==NUM_DIGITS-1, go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1. sum, cout and overflow are stable and held until out_ready is high.
  - On out_valid&&out_ready: go to IDLE; out_valid drops the next cycle.
  - If out_ready is already high on the first DONE cycle, the transfer completes that cycle.
- Latency: acceptance edge at cycle 0; out_valid high from cycle NUM_DIGITS.
- Throughput: one operation per NUM_DIGITS+2 cycles minimum. No overlap of operations.
- overflow = (carry into MSB) XOR (carry out of MSB), captured on the final RUN cycle.
- cout = carry out of MSB, captured on the final RUN cycle.
- After the handshake, sum, cout and overflow keep their last value; only out_valid gates them.
- NUM_DIGITS==1: RUN lasts exactly one cycle. The counter must not underflow or wrap.
- DIGIT==WIDTH is legal and degenerates to a one-RUN-cycle full-width add.
- Reset mid-RUN or mid-DONE: abort immediately to IDLE, all outputs take their reset values, the partial result is discarded.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE/RUN/DONE);
  - elaboration check macro or function asserting WIDTH%DIGIT==0 and DIGIT>=1.
- Sub-module ripple_digit_add: purely combinational DIGIT-wide ripple-carry chain of full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, and c_msb_in (carry into its MSB, used for overflow).
- Top module holds the FSM, digit counter, operand registers, result register and handshake logic.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, cin=0, sub=0. Expect in_ready low for 4 cycles, out_valid on cycle 4, sum=0x5555, cout=0, overflow=0.
- Carry across every digit: a=0xFFFF, b=0x0001, cin=0, sub=0. Expect sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001. Expect sum=0x8000, cout=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1. Expect sum=0xFFFE, cout=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, sub=1. Expect sum=0x7FFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Expect out_valid and sum stable, in_ready=0, in_valid pulses ignored. Raise out_ready: one transfer, back to IDLE, in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 on the second RUN cycle. Expect out_valid=0, sum=0 and state IDLE asynchronously. After release, a fresh 0x0001+0x0001 yields 0x0002.
- Parameter sweep: DIGIT=1 (16 RUN cycles) and DIGIT=16 (1 RUN cycle) with 1000 random operand sets per configuration. Compare against a reference model of a±b±cin mod 2^16, including cout and overflow.
